// File: rtl/key_pkg.sv
// key_pkg: shared direction/key encodings and helpers for the keypad event path.
package key_pkg;
  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;
  localparam logic [3:0] KEY_UP    = 4'h2;
  localparam logic [3:0] KEY_LEFT  = 4'h5;
  localparam logic [3:0] KEY_RIGHT = 4'h7;
  localparam logic [3:0] KEY_DOWN  = 4'ha;
  typedef struct packed {
    logic       is_dir;
    logic [3:0] code;
  } key_ev_t;
  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b10;
  endfunction
  // {is_dir, heading} for a key code
  function automatic logic [2:0] key_dir(input logic [3:0] c);
    return c == KEY_UP    ? {1'b1, DIR_UP}    :
           c == KEY_LEFT  ? {1'b1, DIR_LEFT}  :
           c == KEY_RIGHT ? {1'b1, DIR_RIGHT} :
           c == KEY_DOWN  ? {1'b1, DIR_DOWN}  : 3'b000;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes keydown/code and debounces keydown, pulsing press on each accepted 0->1.
module key_debounce #(
  parameter int DB_CYCLES = 20000,
  parameter int DB_W      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keydown,
  input  logic [3:0] code,
  output logic [3:0] code_s,
  output logic       press
);
  logic [1:0]      r_kd_sync;
  logic [3:0]      r_code_m;
  logic [3:0]      r_code_s;
  logic            r_db;
  logic [DB_W-1:0] r_cnt;
  logic            w_kd_s;
  logic            w_flip;
  assign w_kd_s = r_kd_sync[1];
  assign w_flip = (w_kd_s != r_db) && (r_cnt == DB_W'(DB_CYCLES - 1));
  assign press  = w_flip && !r_db;
  assign code_s = r_code_s;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kd_sync <= '0;
      r_code_m  <= '0;
      r_code_s  <= '0;
      r_db      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_kd_sync <= {r_kd_sync[0], keydown};
      r_code_m  <= code;
      r_code_s  <= r_code_m;
      r_db      <= r_db ^ w_flip;
      r_cnt     <= (w_kd_s == r_db || w_flip) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns debounced keypad presses into queued events and tracks the snake heading.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int DB_CYCLES = 20000,
  parameter int DB_W      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keydown,
  input  logic [3:0] code,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [3:0] ev_code,
  output logic       ev_is_dir,
  output logic [1:0] dir,
  output logic       ovf
);
  logic [3:0] w_code_s;
  logic       w_press;
  logic [2:0] w_kdir;
  logic       w_pop;
  logic       w_push;
  key_ev_t    r_mem [4];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [2:0] r_cnt;
  logic [1:0] r_dir;
  logic       r_ovf;
  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
    .clk     (clk),
    .rst     (rst),
    .keydown (keydown),
    .code    (code),
    .code_s  (w_code_s),
    .press   (w_press)
  );
  assign w_kdir    = key_dir(w_code_s);
  assign w_pop     = ev_ready && ev_valid;
  // a full queue still accepts a press when the head leaves on the same edge
  assign w_push    = w_press && (r_cnt != 3'd4 || w_pop);
  assign ev_valid  = r_cnt != 3'd0;
  assign ev_code   = ev_valid ? r_mem[r_rp].code : 4'h0;
  assign ev_is_dir = ev_valid && r_mem[r_rp].is_dir;
  assign dir       = r_dir;
  assign ovf       = r_ovf;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= '{is_dir: w_kdir[2], code: w_code_s};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_dir <= DIR_RIGHT;
      r_ovf <= 1'b0;
    end else begin
      r_wp  <= r_wp + 2'(w_push);
      r_rp  <= r_rp + 2'(w_pop);
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
      r_ovf <= w_press && !w_push;
      if (w_press && w_kdir[2] && !is_opposite(w_kdir[1:0], r_dir)) r_dir <= w_kdir[1:0];
    end
  end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed checks of debounce, heading, queue and overflow with DB_CYCLES=4.
module tb_key_event_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       keydown = 1'b0;
  logic [3:0] code = 4'h0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_is_dir;
  logic [1:0] dir;
  logic       ovf;
  int         total = 0;
  int         bad = 0;
  int         ovf_cnt = 0;
  key_event_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .keydown   (keydown),
    .code      (code),
    .ev_ready  (ev_ready),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_is_dir (ev_is_dir),
    .dir       (dir),
    .ovf       (ovf)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (ovf) ovf_cnt++;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    keydown = 1'b0;
    ev_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ovf_cnt = 0;
  endtask
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    keydown = 1'b1;
    code = c;
    repeat (8) @(negedge clk);
    keydown = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic pop_expect(input string tag, input logic [3:0] c);
    @(negedge clk);
    check({tag, "_valid"}, 8'(ev_valid), 8'h1);
    check({tag, "_code"}, 8'(ev_code), 8'(c));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask
  initial begin
    #2;
    check("rst_valid", 8'(ev_valid), 8'h0);
    check("rst_code", 8'(ev_code), 8'h0);
    check("rst_dir", 8'(dir), 8'h0);
    check("rst_ovf", 8'(ovf), 8'h0);
    do_reset();
    // clean press: edge 0 is the first posedge after this negedge
    @(negedge clk);
    keydown = 1'b1;
    code = 4'h2;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("clean_early", 8'(ev_valid), 8'h0);
    @(negedge clk);
    check("clean_valid", 8'(ev_valid), 8'h1);
    check("clean_code", 8'(ev_code), 8'h2);
    check("clean_isdir", 8'(ev_is_dir), 8'h1);
    check("clean_dir", 8'(dir), 8'h1);
    repeat (18) @(negedge clk);
    keydown = 1'b0;
    repeat (10) @(negedge clk);
    pop_expect("clean_pop", 4'h2);
    check("clean_single", 8'(ev_valid), 8'h0);
    // bounce
    do_reset();
    code = 4'h2;
    keydown = 1'b1; @(negedge clk);
    keydown = 1'b0; @(negedge clk);
    keydown = 1'b1; @(negedge clk);
    keydown = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_valid", 8'(ev_valid), 8'h0);
    check("bounce_dir", 8'(dir), 8'h0);
    // reversal
    do_reset();
    press(4'h5);
    check("rev_valid", 8'(ev_valid), 8'h1);
    check("rev_code", 8'(ev_code), 8'h5);
    check("rev_isdir", 8'(ev_is_dir), 8'h1);
    check("rev_dir", 8'(dir), 8'h0);
    pop_expect("rev_pop", 4'h5);
    press(4'h2);
    check("rev_up_dir", 8'(dir), 8'h1);
    // overflow
    do_reset();
    press(4'h1);
    check("ovf_nodir", 8'(ev_is_dir), 8'h0);
    press(4'h3);
    press(4'h9);
    press(4'hc);
    check("ovf_none_yet", 8'(ovf_cnt), 8'h0);
    press(4'hf);
    check("ovf_once", 8'(ovf_cnt), 8'h1);
    pop_expect("ovf_p0", 4'h1);
    pop_expect("ovf_p1", 4'h3);
    pop_expect("ovf_p2", 4'h9);
    pop_expect("ovf_p3", 4'hc);
    check("ovf_empty", 8'(ev_valid), 8'h0);
    // full with a pop on the same edge as the 5th push
    do_reset();
    press(4'h1);
    press(4'h3);
    press(4'h9);
    press(4'hc);
    @(negedge clk);
    keydown = 1'b1;
    code = 4'hf;
    repeat (5) @(posedge clk);
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    keydown = 1'b0;
    repeat (8) @(negedge clk);
    check("fp_noovf", 8'(ovf_cnt), 8'h0);
    pop_expect("fp_p0", 4'h3);
    pop_expect("fp_p1", 4'h9);
    pop_expect("fp_p2", 4'hc);
    pop_expect("fp_p3", 4'hf);
    check("fp_empty", 8'(ev_valid), 8'h0);
    // async reset mid-debounce with a pending event and changed heading
    do_reset();
    press(4'ha);
    check("ar_pre_dir", 8'(dir), 8'h3);
    @(negedge clk);
    keydown = 1'b1;
    code = 4'h7;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", 8'(ev_valid), 8'h0);
    check("ar_code", 8'(ev_code), 8'h0);
    check("ar_isdir", 8'(ev_is_dir), 8'h0);
    check("ar_dir", 8'(dir), 8'h0);
    check("ar_ovf", 8'(ovf), 8'h0);
    keydown = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("ar_after_valid", 8'(ev_valid), 8'h0);
    check("ar_after_dir", 8'(dir), 8'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Downstream consumer of the 4x4 keypad scanner: takes its `keydown`/`code` outputs, debounces the press, and turns each clean press into a single queued key event. It also maintains the snake's current heading, rejecting 180° reversals. It sits between the keypad scanner and the game FSM; the game pops events with a valid/ready handshake once per game tick or faster.

## Interface
- `DB_CYCLES`, default 20000: number of consecutive clk cycles the synchronized `keydown` must hold a new level before it is accepted (≥2).
- `DB_W`, default 15: debounce counter width; must satisfy 2^DB_W ≥ DB_CYCLES.
- `clk`  in  1: system clock, the same clock that drives the keypad scanner.
- `rst`  in  1: asynchronous, active-low reset.
- `keydown`  in  1: scanner key-held flag, from the scan_clk domain; treated as asynchronous.
- `code`  in  4: scanner key code; treated as asynchronous, and stable while a key is held.
- `ev_ready`  in  1: consumer pops the head event when `ev_valid & ev_ready`.
- `ev_valid`  out  1: event queue is non-empty.
- `ev_code`  out  4: key code of the head event.
- `ev_is_dir`  out  1: head event is a direction key.
- `dir`  out  2: current heading (00 right, 01 up, 10 left, 11 down).
- `ovf`  out  1: one-cycle pulse when a press is dropped because the queue is full.

## Operation
- Synchronizer: `keydown` and `code` each pass through 2-flop synchronizers, giving `kd_s` and `code_s`.
- Debounce: register `db` and counter `cnt`.
  - If `kd_s == db`: `cnt` is set to 0.
  - Otherwise, if `cnt == DB_CYCLES-1`: `db` toggles and `cnt` is set to 0.
  - Otherwise `cnt` increments.
  - Any glitch shorter than DB_CYCLES restarts the count.
- Press detect: on the edge where `db` goes 0→1, `code_s` is captured and pushed. The 1→0 transition (release) produces no event. A held key produces exactly one event (no auto-repeat).
- Direction map:
  - 4'h2 = up
  - 4'h5 = left
  - 4'h7 = right
  - 4'ha = down
  - All other codes push with `ev_is_dir`=0.
- Heading: on a direction press, `dir` updates on the same edge as the push, unless the new direction is the exact opposite of the current `dir`. A reversal is still queued as an event, but `dir` is unchanged.
- Queue: 4-entry circular FIFO of {is_dir, code}, with 2-bit read/write pointers and a 3-bit count.
  - Push when full and no pop: the event is dropped, `dir` still updates per the rule above, and `ovf` pulses for 1 cycle.
  - Push and pop on the same edge when full: the pop completes, the push is accepted, and count stays 4.
  - Push and pop on the same edge when not full or empty: count is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo 4.
- Reset values:
  - `db`=0, `cnt`=0, synchronizers 0, FIFO empty.
  - `ev_valid`=0, `ev_code`=0, `ev_is_dir`=0, `dir`=00, `ovf`=0.
  - Reset mid-debounce or mid-queue discards all pending state immediately.

## Timing
- Take edge 0 as the first edge that samples `keydown`=1. Then:
  - `kd_s`=1 after edge 1.
  - Counting runs on edges 2…DB_CYCLES+1.
  - `db`, the FIFO write and `dir` all update at edge DB_CYCLES+1.
  - If the queue was empty, `ev_valid` is 1 after edge DB_CYCLES+1.
- Release is accepted DB_CYCLES+1 edges after `keydown` is first sampled 0.
- `ev_*` outputs are combinational reads of the head entry. They change only on the edge after a pop or after a push to an empty queue.
- `ev_valid` stays high until popped. The consumer may hold `ev_ready` high continuously, giving one pop per cycle.
- `ovf` is registered and asserted during the cycle following the dropped push.

## Structure
- Shared package `key_pkg`:
  - Direction encodings `DIR_RIGHT`/`DIR_UP`/`DIR_LEFT`/`DIR_DOWN`.
  - Key constants `KEY_UP`=4'h2, `KEY_LEFT`=4'h5, `KEY_RIGHT`=4'h7, `KEY_DOWN`=4'ha.
  - Function `is_opposite(a,b)`, defined as a^b==2'b10.
- One sub-module, `key_debounce`: synchronizer, counter and `db` register, plus a `press` pulse output.
- The FIFO and heading logic stay in `key_event_ctrl`.

## Test plan
All scenarios run with DB_CYCLES=4.
- Clean press: `keydown`=1 and `code`=4'h2 held for 20 cycles, `ev_ready`=0.
  - `ev_valid` rises after edge 5 with `ev_code`=2, `ev_is_dir`=1 and `dir`=01.
  - A single event is queued.
- Bounce: `keydown` toggles 1,0,1,0 on consecutive cycles, then goes low.
  - No event is queued and `dir` stays 00.
- Reversal: with `dir`=00 (right), press 4'h5 (left).
  - The event is queued with `ev_is_dir`=1, and `dir` stays 00.
  - A subsequent press of 4'h2 sets `dir`=01.
- Overflow: 5 distinct presses (4'h1, 4'h3, 4'h9, 4'hc, 4'hf) with `ev_ready`=0.
  - 4 events are held, and `ovf` pulses once on the 5th press.
  - Popping then returns 1, 3, 9, c in order.
- Full with simultaneous pop: queue full, `ev_ready`=1 on the same edge as a 5th push.
  - Count stays 4, and the new code appears last after 3 further pops.
- Async reset mid-debounce: `rst` is pulled low 2 cycles into counting, then released.
  - All outputs return to their reset values immediately.
  - No event is queued if `keydown` is low after release.
